sr_latch_bank_driver: RTL

//  Drive side of the SR-latch interface: turns write/clear requests into legal S/R/En/clear sequences
//  for a bank of WIDTH SR latches with async clear. It then reads back Q to verify the result.

---
 rtl/sr_latch_bank_driver_if.sv | 28 ++
 rtl/sr_latch_bank_driver.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sr_latch_bank_driver_if.sv
// Request bus and latch-bank wiring between a register-write master and the SR-latch driver.
interface sr_latch_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             En;
    logic             clear;
    logic [WIDTH-1:0] q_in;
    logic             done;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output req_valid, req_op, req_data, req_mask, q_in,
        input  req_ready, S, R, En, clear, done, err, err_cnt
    );

    modport slave (
        input  req_valid, req_op, req_data, req_mask, q_in,
        output req_ready, S, R, En, clear, done, err, err_cnt
    );
endinterface

// File: rtl/sr_latch_bank_driver.sv
// Sequences masked writes and bank clears onto a bank of SR latches with setup/enable/hold timing,
// then reads Q back and flags mismatches.
module sr_latch_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sr_latch_bank_driver_if.slave   bus
);
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_CLEAR,
        ST_CHECK
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_load_val;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_mask;
    logic               r_op;
    logic               r_done;
    logic               r_err;
    logic [7:0]         r_err_cnt;
    logic               w_ready;
    logic               w_accept;
    logic               w_err;

    assign w_ready  = (r_state == ST_IDLE) && rst_n;
    assign w_accept = bus.req_valid && w_ready;
    assign w_err    = r_op ? (|bus.q_in) : (|((bus.q_in ^ r_data) & r_mask));

    // The dwell counter reloads whenever the state changes and counts down to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= w_load_val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_val   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = bus.req_op ? ST_CLEAR : ST_SETUP;
                end
            end
            ST_SETUP:  if (r_cnt == '0) w_next_state = ST_ENABLE;
            ST_ENABLE: if (r_cnt == '0) w_next_state = ST_HOLD;
            ST_HOLD:   if (r_cnt == '0) w_next_state = ST_CHECK;
            ST_CLEAR:  if (r_cnt == '0) w_next_state = ST_CHECK;
            ST_CHECK:  w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        case (w_next_state)
            ST_SETUP:           w_load_val = CNT_W'(SETUP_CYC - 1);
            ST_ENABLE, ST_CLEAR: w_load_val = CNT_W'(EN_CYC - 1);
            ST_HOLD:            w_load_val = CNT_W'(HOLD_CYC - 1);
            default:            w_load_val = '0;
        endcase
    end

    // done/err are registered at the end of CHECK, so they appear together with req_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_mask    <= '0;
            r_op      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_done <= (r_state == ST_CHECK);
            if (w_accept) begin
                r_data <= bus.req_data;
                r_mask <= bus.req_mask;
                r_op   <= bus.req_op;
                r_err  <= 1'b0;
            end
            if (r_state == ST_CHECK) begin
                r_err <= w_err;
                if (w_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    // S and R come from complementary halves of the mask, so they can never both be set.
    always_comb begin
        bus.req_ready = w_ready;
        bus.S         = '0;
        bus.R         = '0;
        bus.En        = 1'b0;
        bus.clear     = 1'b0;
        case (r_state)
            ST_SETUP, ST_HOLD: begin
                bus.S = r_mask & r_data;
                bus.R = r_mask & ~r_data;
            end
            ST_ENABLE: begin
                bus.S  = r_mask & r_data;
                bus.R  = r_mask & ~r_data;
                bus.En = 1'b1;
            end
            ST_CLEAR: bus.clear = 1'b1;
            default: ;
        endcase
        bus.done    = r_done;
        bus.err     = r_err;
        bus.err_cnt = r_err_cnt;
    end
endmodule
